// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// CSR addresses and the channel ceiling that fixes the 4-bit channel code.
package irq_pkg;

    localparam int MAX_CH = 16;

    localparam logic [1:0] CSR_MASK   = 2'd0;
    localparam logic [1:0] CSR_PEND   = 2'd1;
    localparam logic [1:0] CSR_ISR    = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: valid flag plus 4-bit index of the
// lowest set request bit.
module irq_prio_enc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [3:0]       idx
);

    // NOTE: every output is given a default before the loop, so no path
    // leaves it unassigned and no latch is inferred. Scanning from the top
    // down with blocking assignments lets the lowest set bit overwrite last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-channel edge/level latching, masking, lowest-index
// priority, INTA/EOI in-service tracking and a 4-entry CSR port.
// Define IRQ_NEST_EN to let a higher-priority request preempt one in service.
module irq_controller
    import irq_pkg::*;
#(
    parameter int                NUM_CH    = 16,
    parameter logic [MAX_CH-1:0] TRIG_EDGE = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] SRC,
    input  logic              IE,
    input  logic              INTA,
    input  logic              EOI,
    output logic              IRQ,
    output logic [3:0]        IC,
    input  logic [1:0]        CSR_SEL,
    input  logic              CSR_W,
    input  logic [15:0]       CSR_DIN,
    output logic [15:0]       CSR_DOUT
);

    localparam logic [NUM_CH-1:0] ONE  = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] TRIG = TRIG_EDGE[NUM_CH-1:0];

    irq_state_t        state;
    logic              irqReg;
    logic [3:0]        icReg;
    logic [NUM_CH-1:0] mask, pend, isr, srcPrev;
    logic [NUM_CH-1:0] setEv, pendClr, pendNext, eoiClr, intaSet, isrNext;
    logic [MAX_CH-1:0] maskFull;
    logic              eValid, isrValid, intaTake, nestReq;
    logic [3:0]        eIdx, isrIdx;

    irq_prio_enc #(.WIDTH(NUM_CH)) u_enc_eligible (
        .req   (pend & mask),
        .valid (eValid),
        .idx   (eIdx)
    );

    irq_prio_enc #(.WIDTH(NUM_CH)) u_enc_isr (
        .req   (isr),
        .valid (isrValid),
        .idx   (isrIdx)
    );

    assign intaTake = (state == REQ) && INTA;

    // Set events win over any clear on the same channel in the same cycle.
    always_comb begin
        setEv   = SRC & (~TRIG | ~srcPrev);
        pendClr = '0;
        if (intaTake)
            pendClr = pendClr | (ONE << icReg);
        if (CSR_W && (CSR_SEL == CSR_PEND))
            pendClr = pendClr | CSR_DIN[NUM_CH-1:0];
        pendNext = (pend & ~pendClr) | setEv;

        // EOI retires the top in-service bit before INTA adds a new one.
        eoiClr  = (EOI && isrValid) ? (ONE << isrIdx) : '0;
        intaSet = intaTake ? (ONE << icReg) : '0;
        isrNext = (isr & ~eoiClr) | intaSet;

        maskFull             = '0;
        maskFull[NUM_CH-1:0] = mask;
    end

`ifdef IRQ_NEST_EN
    assign nestReq = IE && eValid && isrValid && (eIdx < isrIdx) && !EOI;
`else
    assign nestReq = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments only, so every
    // reader in this block sees the values from before the clock edge.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            // Synchronous reset clears every register; nothing here is a
            // memory array, so nothing is left uninitialised.
            mask    <= '0;
            pend    <= '0;
            isr     <= '0;
            srcPrev <= '0;
            irqReg  <= 1'b0;
            icReg   <= '0;
            state   <= IDLE;
        end else begin
            srcPrev <= SRC;
            pend    <= pendNext;
            isr     <= isrNext;
            if (CSR_W && (CSR_SEL == CSR_MASK))
                mask <= CSR_DIN[NUM_CH-1:0];

            case (state)
                IDLE: begin
                    if (IE && eValid) begin
                        icReg  <= eIdx;
                        irqReg <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (INTA) begin
                        irqReg <= 1'b0;
                        state  <= SERVICE;
                    end else if (!IE || !maskFull[icReg]) begin
                        irqReg <= 1'b0;
                        state  <= (isrNext != '0) ? SERVICE : IDLE;
                    end
                end
                SERVICE: begin
                    if (isrNext == '0) begin
                        state <= IDLE;
                    end else if (nestReq) begin
                        icReg  <= eIdx;
                        irqReg <= 1'b1;
                        state  <= REQ;
                    end
                end
                default: begin
                    irqReg <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign IRQ = irqReg;
    assign IC  = icReg;

    always_comb begin
        CSR_DOUT = '0;
        case (CSR_SEL)
            CSR_MASK: CSR_DOUT[NUM_CH-1:0] = mask;
            CSR_PEND: CSR_DOUT[NUM_CH-1:0] = pend;
            CSR_ISR:  CSR_DOUT[NUM_CH-1:0] = isr;
            default:  CSR_DOUT = {9'b0, state, irqReg, icReg};
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a table of one-cycle vectors with
// hand-computed results, plus hand-written reset and timeout sequences.
module tb_irq_controller;
    import irq_pkg::*;

`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] SRC;
    logic        IE, INTA, EOI;
    logic        IRQ;
    logic [3:0]  IC;
    logic [1:0]  CSR_SEL;
    logic        CSR_W;
    logic [15:0] CSR_DIN;
    logic [15:0] CSR_DOUT;

    int nChecks = 0;
    int nFails  = 0;

    irq_controller #(
        .NUM_CH    (16),
        .TRIG_EDGE (16'hFFEF)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SRC      (SRC),
        .IE       (IE),
        .INTA     (INTA),
        .EOI      (EOI),
        .IRQ      (IRQ),
        .IC       (IC),
        .CSR_SEL  (CSR_SEL),
        .CSR_W    (CSR_W),
        .CSR_DIN  (CSR_DIN),
        .CSR_DOUT (CSR_DOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] src;
        logic        ie, inta, eoi, csrW;
        logic [1:0]  csrSel;
        logic [15:0] csrDin;
        logic [1:0]  rdSel;
        logic        expIrq;
        logic [3:0]  expIc;
        logic [15:0] expDout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic [15:0] src, logic ie, logic inta,
                                logic eoi, logic csrW, logic [1:0] csrSel,
                                logic [15:0] csrDin, logic [1:0] rdSel, logic expIrq,
                                logic [3:0] expIc, logic [15:0] expDout);
        vec_t v;
        v.name = name;   v.src = src;       v.ie = ie;         v.inta = inta;
        v.eoi = eoi;     v.csrW = csrW;     v.csrSel = csrSel; v.csrDin = csrDin;
        v.rdSel = rdSel; v.expIrq = expIrq; v.expIc = expIc;   v.expDout = expDout;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic readCsr(string name, logic [1:0] sel, logic [15:0] exp);
        CSR_SEL = sel;
        #1;
        check(name, 32'(CSR_DOUT), 32'(exp));
    endtask

    // Drive one vector for a cycle, then drop strobes and compare after the edge.
    task automatic apply(vec_t v);
        SRC = v.src;  IE = v.ie;  INTA = v.inta;  EOI = v.eoi;
        CSR_W = v.csrW;  CSR_SEL = v.csrSel;  CSR_DIN = v.csrDin;
        @(posedge CLK);
        #1;
        INTA = 1'b0;  EOI = 1'b0;  CSR_W = 1'b0;  CSR_SEL = v.rdSel;
        #1;
        check({v.name, " IRQ"}, 32'(IRQ), 32'(v.expIrq));
        check({v.name, " IC"}, 32'(IC), 32'(v.expIc));
        check({v.name, " CSR"}, 32'(CSR_DOUT), 32'(v.expDout));
    endtask

    task automatic waitIrq(string name, int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            #1;
            if (IRQ) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0;  SRC = '0;  IE = 1'b0;  INTA = 1'b0;  EOI = 1'b0;
        CSR_SEL = '0;  CSR_W = 1'b0;  CSR_DIN = '0;

        // Basic request / acknowledge / end-of-interrupt on channel 2
        add("mask5 write",   16'h0000, 1, 0, 0, 1, CSR_MASK, 16'h0005, CSR_MASK,   0, 4'd0, 16'h0005);
        add("src2 pend",     16'h0004, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd0, 16'h0004);
        add("src2 irq",      16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd2, 16'h0032);
        add("src2 inta",     16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd2, 16'h0004);
        add("src2 pendclr",  16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd2, 16'h0000);
        add("src2 service",  16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 0, 4'd2, 16'h0042);
        add("src2 eoi",      16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd2, 16'h0000);
        add("src2 idle",     16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 0, 4'd2, 16'h0002);
        // Simultaneous channels 7 and 3: lowest index first
        add("maskall",       16'h0000, 1, 0, 0, 1, CSR_MASK, 16'hFFFF, CSR_MASK,   0, 4'd2, 16'hFFFF);
        add("src73 pend",    16'h0088, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd2, 16'h0088);
        add("src73 irq3",    16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd3, 16'h0033);
        add("src73 inta3",   16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd3, 16'h0008);
        add("src73 eoi3",    16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd3, 16'h0000);
        add("src73 irq7",    16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd7, 16'h0037);
        add("src73 inta7",   16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd7, 16'h0080);
        add("src73 eoi7",    16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd7, 16'h0000);
        add("src73 idle",    16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 0, 4'd7, 16'h0007);
        // Masking the requested channel withdraws IRQ but keeps it pending
        add("src5 pend",     16'h0020, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd7, 16'h0020);
        add("src5 irq",      16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd5, 16'h0035);
        add("mask5 off",     16'h0000, 1, 0, 0, 1, CSR_MASK, 16'hFFDF, CSR_MASK,   1, 4'd5, 16'hFFDF);
        add("src5 withdraw", 16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd5, 16'h0020);
        add("mask5 on",      16'h0000, 1, 0, 0, 1, CSR_MASK, 16'hFFFF, CSR_STATUS, 0, 4'd5, 16'h0005);
        add("src5 reirq",    16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd5, 16'h0035);
        add("src5 inta",     16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd5, 16'h0020);
        add("src5 eoi",      16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd5, 16'h0000);
        // IE gating and write-1-to-clear of PEND
        add("ie0 src1",      16'h0002, 0, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd5, 16'h0002);
        add("ie0 hold",      16'h0000, 0, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd5, 16'h0002);
        add("ie1 irq1",      16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd1, 16'h0031);
        add("src1 inta",     16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd1, 16'h0002);
        add("src1 eoi",      16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd1, 16'h0000);
        add("w1c src1",      16'h0002, 0, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd1, 16'h0002);
        add("w1c clear",     16'h0000, 0, 0, 0, 1, CSR_PEND, 16'h0002, CSR_PEND,   0, 4'd1, 16'h0000);
        add("w1c noirq",     16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 0, 4'd1, 16'h0001);
        add("w1c setwins",   16'h0100, 0, 0, 0, 1, CSR_PEND, 16'h0100, CSR_PEND,   0, 4'd1, 16'h0100);
        add("w1c clear8",    16'h0000, 0, 0, 0, 1, CSR_PEND, 16'h0100, CSR_PEND,   0, 4'd1, 16'h0000);
        add("isr ro",        16'h0000, 0, 0, 0, 1, CSR_ISR,  16'hFFFF, CSR_ISR,    0, 4'd1, 16'h0000);
        add("status ro",     16'h0000, 0, 0, 0, 1, CSR_STATUS, 16'hFFFF, CSR_STATUS, 0, 4'd1, 16'h0001);
        // Level-triggered channel 4 re-pends while held high
        add("lvl4 pend",     16'h0010, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd1, 16'h0010);
        add("lvl4 irq",      16'h0010, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd4, 16'h0034);
        add("lvl4 inta",     16'h0010, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd4, 16'h0010);
        add("lvl4 repend",   16'h0010, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd4, 16'h0010);
        add("lvl4 eoi",      16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd4, 16'h0000);
        add("lvl4 reirq",    16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd4, 16'h0034);
        add("lvl4 inta2",    16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd4, 16'h0010);
        add("lvl4 eoi2",     16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd4, 16'h0000);
        add("lvl4 done",     16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd4, 16'h0000);
        // Channel 2 arriving while channel 6 is in service
        add("svc6 pend",     16'h0040, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd4, 16'h0040);
        add("svc6 irq",      16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS, 1, 4'd6, 16'h0036);
        add("svc6 inta",     16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,    0, 4'd6, 16'h0040);
        add("svc6 src2",     16'h0004, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_PEND,   0, 4'd6, 16'h0004);
        add("svc6 nestreq",  16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS,
            NEST, NEST ? 4'd2 : 4'd6, NEST ? 16'h0032 : 16'h0046);
        add("svc6 nestinta", 16'h0000, 1, 1, 0, 0, CSR_MASK, 16'h0000, CSR_ISR,
            0, NEST ? 4'd2 : 4'd6, NEST ? 16'h0044 : 16'h0040);
        add("svc6 eoi1",     16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,
            0, NEST ? 4'd2 : 4'd6, NEST ? 16'h0040 : 16'h0000);
        add("svc6 after1",   16'h0000, 1, 0, 0, 0, CSR_MASK, 16'h0000, CSR_STATUS,
            !NEST, 4'd2, NEST ? 16'h0042 : 16'h0032);
        add("svc6 eoi+inta", 16'h0000, 1, 1, 1, 0, CSR_MASK, 16'h0000, CSR_ISR,
            0, 4'd2, NEST ? 16'h0000 : 16'h0004);
        add("svc6 final",    16'h0000, 1, 0, 1, 0, CSR_MASK, 16'h0000, CSR_STATUS, 0, 4'd2, 16'h0002);

        // Reset state
        cycle();
        cycle();
        check("reset IRQ", 32'(IRQ), 32'd0);
        check("reset IC", 32'(IC), 32'd0);
        readCsr("reset MASK", CSR_MASK, 16'h0000);
        readCsr("reset PEND", CSR_PEND, 16'h0000);
        readCsr("reset ISR", CSR_ISR, 16'h0000);
        readCsr("reset STATUS", CSR_STATUS, 16'h0000);
        RST = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Highest channel, then reset while in service aborts it
        SRC = 16'h8000;
        cycle();
        SRC = 16'h0000;
        waitIrq("ch15 irq timeout", 8);
        check("ch15 IC", 32'(IC), 32'd15);
        INTA = 1'b1;
        cycle();
        INTA = 1'b0;
        readCsr("ch15 ISR", CSR_ISR, 16'h8000);
        RST = 1'b0;
        cycle();
        RST = 1'b1;
        check("svc reset IRQ", 32'(IRQ), 32'd0);
        check("svc reset IC", 32'(IC), 32'd0);
        readCsr("svc reset ISR", CSR_ISR, 16'h0000);
        readCsr("svc reset MASK", CSR_MASK, 16'h0000);
        readCsr("svc reset STATUS", CSR_STATUS, 16'h0000);
        EOI = 1'b1;
        cycle();
        EOI = 1'b0;
        readCsr("stray eoi ISR", CSR_ISR, 16'h0000);
        readCsr("stray eoi STATUS", CSR_STATUS, 16'h0000);

        // Reset while a request is outstanding
        CSR_SEL = CSR_MASK;  CSR_DIN = 16'hFFFF;  CSR_W = 1'b1;
        cycle();
        CSR_W = 1'b0;
        SRC = 16'h0001;
        cycle();
        SRC = 16'h0000;
        waitIrq("ch0 irq timeout", 8);
        check("ch0 IC", 32'(IC), 32'd0);
        readCsr("ch0 STATUS", CSR_STATUS, 16'h0030);
        RST = 1'b0;
        cycle();
        RST = 1'b1;
        check("req reset IRQ", 32'(IRQ), 32'd0);
        readCsr("req reset PEND", CSR_PEND, 16'h0000);
        readCsr("req reset STATUS", CSR_STATUS, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
